rle_enc_wide: RTL and testbench

Parametrised run-length encoder that sits between an input-side bit-stream FIFO and an output-side code FIFO. It reads IN_W-bit words, scans them LSB-first one bit per cycle, and writes one {bit value, run length} code per run. Long runs are split at counter saturation, and the last open run is flushed on end_of_stream. Input word width and count width are generalised.

---
 rtl/rle_enc_wide.sv | 161 ++++++++++++++++
 tb/tb_rle_enc_wide.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_enc_wide.sv
// rle_enc_wide: LSB-first run-length encoder between a bit-stream word FIFO
// and a code FIFO. Each code is {bit value, run length}. Runs longer than the
// counter can hold are split at saturation, and the open run is flushed on
// end_of_stream.
// Optional build macro: RLE_ENC_STATS_EN adds the 32-bit seg_total code counter.
//
// Handshakes (both sides are FIFO strobes, not valid/ready pairs):
//   rd_req  is a one-cycle pulse issued only from REQ while recv_ready=1; the
//           word arrives on in_data the following cycle and is captured then.
//   wr_req  is a one-cycle pulse in WRITE, which is only entered after a cycle
//           with send_ready=1; out_data holds the code from EMIT entry through
//           the WRITE cycle.
// The FSM state register (state_q) is kept as a named flop for checker binding.
module rle_enc_wide #(
    parameter int IN_W  = 8,
    parameter int CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recv_ready,
    output logic             rd_req,
    input  logic [IN_W-1:0]  in_data,
    input  logic             end_of_stream,
    input  logic             send_ready,
    output logic             wr_req,
    output logic [CNT_W:0]   out_data
`ifdef RLE_ENC_STATS_EN
    ,
    output logic [31:0]      seg_total
`endif
);

    localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SCAN,
        ST_EMIT,
        ST_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              value_q, value_d;
    logic              flush_q, flush_d;

    // The code under construction is always visible; it is frozen during
    // EMIT/WRITE because nothing updates the run while waiting to write.
    assign out_data = {value_q, count_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            value_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            value_q <= value_d;
            flush_q <= flush_d;
        end
    end

    // Next-state, datapath update and strobe generation.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        count_d = count_q;
        value_d = value_q;
        flush_d = flush_q;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // Pending input wins over end_of_stream so the FIFO drains first.
                if (recv_ready) begin
                    rd_req  = 1'b1;
                    state_d = ST_WAIT;
                end else if (end_of_stream && (count_q != '0)) begin
                    flush_d = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_WAIT: begin
                buf_d   = in_data;
                idx_d   = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if ((count_q == '0) || ((buf_q[0] == value_q) && (count_q != CNT_MAX))) begin
                    if (count_q == '0) begin
                        value_d = buf_q[0];
                    end
                    count_d = count_q + CNT_W'(1);
                    buf_d   = buf_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_REQ;
                    end
                end else begin
                    // Run ended or counter full: emit, keep the bit for the next run.
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (send_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_req  = 1'b1;
                count_d = '0;
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef RLE_ENC_STATS_EN
    logic [31:0] seg_total_q, seg_total_d;

    assign seg_total = seg_total_q;

    // Count every code written; wraps naturally at 2^32.
    always_comb begin
        seg_total_d = seg_total_q;
        if (state_q == ST_WRITE) begin
            seg_total_d = seg_total_q + 32'd1;
        end
    end

    // Statistics register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_total_q <= '0;
        end else begin
            seg_total_q <= seg_total_d;
        end
    end
`endif

endmodule

// File: tb/tb_rle_enc_wide.sv
// tb_rle_enc_wide: directed bench for rle_enc_wide. A main instance
// (IN_W=8, CNT_W=23) and a narrow-counter instance (CNT_W=4) share the input
// stimulus; only one is out of reset at a time and sel4 picks which one is
// observed.
module tb_rle_enc_wide;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic rst4;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        recv_ready;
    logic [7:0]  in_data;
    logic        end_of_stream;
    logic        send_ready;

    logic        rd8, wr8, rd4, wr4;
    logic [23:0] out8;
    logic [4:0]  out4;
`ifdef RLE_ENC_STATS_EN
    logic [31:0] seg8, seg4;
`endif

    rle_enc_wide #(.IN_W(8), .CNT_W(23)) dut (
        .clk(clk), .rst(rst), .recv_ready(recv_ready), .rd_req(rd8),
        .in_data(in_data), .end_of_stream(end_of_stream),
        .send_ready(send_ready), .wr_req(wr8), .out_data(out8)
`ifdef RLE_ENC_STATS_EN
        , .seg_total(seg8)
`endif
    );

    rle_enc_wide #(.IN_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .recv_ready(recv_ready), .rd_req(rd4),
        .in_data(in_data), .end_of_stream(end_of_stream),
        .send_ready(send_ready), .wr_req(wr4), .out_data(out4)
`ifdef RLE_ENC_STATS_EN
        , .seg_total(seg4)
`endif
    );

    logic        sel4;
    logic        act_rd, act_wr;
    logic [23:0] act_out;
    assign act_rd  = sel4 ? rd4 : rd8;
    assign act_wr  = sel4 ? wr4 : wr8;
    assign act_out = sel4 ? {19'd0, out4} : out8;

    // ---------------- scoreboard ----------------
    logic [7:0]  words_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_cnt   = 0;
    int          overlap  = 0;
    logic        eos_en   = 1'b0;
    logic        rd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < got_q.size()) ? {8'd0, got_q[i]} : 32'hFFFF_FFFF, {8'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock: observe outputs at negedge, then update inputs 1 time unit
    // after the rising edge acting as the FIFOs would.
    task automatic cyc();
        @(negedge clk);
        if (act_wr) got_q.push_back(act_out);
        if (act_rd) rd_cnt++;
        if (act_rd && act_wr) overlap++;
        rd_seen = act_rd;
        @(posedge clk);
        #1;
        if (rd_seen && (words_q.size() != 0)) in_data = words_q.pop_front();
        recv_ready    = (words_q.size() != 0);
        end_of_stream = eos_en && (words_q.size() == 0);
    endtask

    task automatic load(input logic [7:0] w, input logic eos_after);
        words_q.push_back(w);
        eos_en        = eos_after;
        recv_ready    = 1'b1;
        end_of_stream = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; rst4 = 1'b1; sel4 = 1'b0;
        recv_ready = 1'b0; in_data = 8'h00; end_of_stream = 1'b0; send_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_req", rd8, 1'b0);
        chk("rst_wr_req", wr8, 1'b0);
        chk("rst_out_data", out8, 24'h0);
        chk("rst4_out_data", out4, 5'h0);
`ifdef RLE_ENC_STATS_EN
        chk("rst_seg_total", seg8, 32'd0);
`endif
        @(posedge clk);
        #1;

        // end_of_stream with empty run: 50 idle cycles, no writes or reads
        eos_en = 1'b1; end_of_stream = 1'b1;
        repeat (50) cyc();
        chk("eos_idle_writes", got_q.size(), 0);
        chk("eos_idle_reads", rd_cnt, 0);
`ifdef RLE_ENC_STATS_EN
        chk("eos_idle_seg_total", seg8, 32'd0);
`endif

        // 0xFF, 0x00, flush
        load(8'hFF, 1'b0); load(8'h00, 1'b1);
        repeat (60) cyc();
        exp_q = '{24'h800008, 24'h000008};
        check_writes("ff00");
        chk("ff00_reads", rd_cnt, 2);
`ifdef RLE_ENC_STATS_EN
        chk("ff00_seg_total", seg8, 32'd2);
`endif

        // 0xAA: alternating single-bit runs
        load(8'hAA, 1'b1);
        repeat (60) cyc();
        exp_q = '{24'h000001, 24'h800001, 24'h000001, 24'h800001,
                  24'h000001, 24'h800001, 24'h000001, 24'h800001};
        check_writes("aa");

        // Back-pressure: 0x01 emits {1,1} at bit 1 while send_ready is low
        send_ready = 1'b0;
        load(8'h01, 1'b0);
        rd_cnt = 0;
        repeat (5) cyc();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_wr_req", wr8, 1'b0);
            chk("stall_rd_req", rd8, 1'b0);
            chk("stall_out_data", out8, 24'h800001);
            @(posedge clk);
            #1;
        end
        chk("stall_no_write", got_q.size(), 0);
        send_ready = 1'b1;
        repeat (20) cyc();
        exp_q = '{24'h800001};
        check_writes("stall_release");
        chk("stall_reads", rd_cnt, 1);
        eos_en = 1'b1; end_of_stream = 1'b1;
        repeat (20) cyc();
        exp_q = '{24'h000007};
        check_writes("stall_flush");

        // Reset mid-SCAN after loading 0x0F
        load(8'h0F, 1'b0);
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd_req", rd8, 1'b0);
        chk("midrst_wr_req", wr8, 1'b0);
        chk("midrst_out_data", out8, 24'h0);
        @(posedge clk);
        #1;
        chk("midrst_no_write", got_q.size(), 0);
        load(8'hF0, 1'b1);
        repeat (60) cyc();
        exp_q = '{24'h000004, 24'h800004};
        check_writes("after_rst_f0");

        // Narrow counter: 24 ones split at 15
        rst = 1'b1; sel4 = 1'b1; rst4 = 1'b0;
        load(8'hFF, 1'b0); load(8'hFF, 1'b0); load(8'hFF, 1'b1);
        repeat (100) cyc();
        exp_q = '{24'h00001F, 24'h000019};
        check_writes("sat4");

        chk("rd_wr_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
